// File: rtl/rc5_job_scheduler_if.sv
// Job request and response channels between two requesters, a result consumer
// and rc5_job_scheduler.
interface rc5_job_scheduler_if #(
  parameter int W = 16
);
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_data0;
  logic [W-1:0] req_data1;
  logic [7:0]   req_seed0;
  logic [7:0]   req_seed1;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_src;
  logic         rsp_op;
  logic         rsp_err;

  modport master (
    output req_valid, req_op, req_data0, req_data1, req_seed0, req_seed1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_src, rsp_op, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_data0, req_data1, req_seed0, req_seed1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_src, rsp_op, rsp_err
  );
endinterface

// File: rtl/rc5_job_scheduler.sv
// Round-robin scheduler sharing one RC5 enc/dec core between two requesters.
// Define RC5_SCHED_WDOG_EN to add a RUN watchdog that aborts with rsp_err after TO_CYC clocks.
module rc5_job_scheduler #(
  parameter int W      = 16,
  parameter int R      = 3,
  parameter int TO_CYC = 1023
) (
  input  logic         clock,
  input  logic         reset,
  rc5_job_scheduler_if.slave bus,
  output logic         busy,
  output logic         core_run,
  output logic         core_enc_start,
  output logic         core_dec_start,
  output logic [7:0]   core_seed_enc,
  output logic [7:0]   core_seed_dec,
  output logic [W-1:0] core_p_in,
  output logic [W-1:0] core_c_in,
  input  logic [W-1:0] core_c_out,
  input  logic [W-1:0] core_p_out,
  input  logic         core_enc_done,
  input  logic         core_dec_done
);

  if (W < 1 || R < 1 || TO_CYC < 1 || TO_CYC > 65536) begin : g_param_check
    $error("rc5_job_scheduler: illegal W/R/TO_CYC");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RESP
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic         ptr;
  logic         grant;
  logic         any_valid;
  logic         accept;
  logic [1:0]   ready;
  logic         drive_core;
  logic         done_sel;
  logic         done_ok;
  logic         first_q;
  logic         op_q;
  logic         src_q;
  logic [W-1:0] data_q;
  logic [7:0]   seed_q;
  logic [W-1:0] result_q;
  logic         err_q;
  logic         wdog_hit;

  // Pointer's requester wins when it is asking; otherwise the other one.
  assign any_valid = |bus.req_valid;
  assign grant     = bus.req_valid[ptr] ? ptr : ~ptr;
  assign accept    = (state == S_IDLE) && any_valid && !reset;

  // The first RUN cycle still sees the done level left over from the previous job.
  assign done_sel = op_q ? core_dec_done : core_enc_done;
  assign done_ok  = (state == S_RUN) && !first_q && done_sel;

`ifdef RC5_SCHED_WDOG_EN
  logic [15:0] wdog_cnt;

  assign wdog_hit = (state == S_RUN) && !done_ok && (wdog_cnt == 16'(TO_CYC - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      wdog_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == S_LOAD)     wdog_cnt <= '0;
      else if (state == S_RUN) wdog_cnt <= wdog_cnt + 16'd1;
      if (done_ok)             err_q    <= 1'b0;
      else if (wdog_hit)       err_q    <= 1'b1;
    end
  end
`else
  assign wdog_hit = 1'b0;
  assign err_q    = 1'b0;
`endif

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt      = state;
    ready          = 2'b00;
    busy           = 1'b1;
    drive_core     = 1'b0;
    core_run       = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_data   = '0;
    bus.rsp_src    = 1'b0;
    bus.rsp_op     = 1'b0;
    bus.rsp_err    = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) begin
          ready[grant] = 1'b1;
          state_nxt    = S_LOAD;
        end
      end
      S_LOAD: begin
        drive_core = 1'b1;
        state_nxt  = S_RUN;
      end
      S_RUN: begin
        drive_core = 1'b1;
        core_run   = 1'b1;
        if (done_ok || wdog_hit) state_nxt = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = result_q;
        bus.rsp_src   = src_q;
        bus.rsp_op    = op_q;
        bus.rsp_err   = err_q;
        if (bus.rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.req_ready = ready;

  // Only the latched op's inputs and start are driven; the other side stays at zero.
  always_comb begin
    core_enc_start = 1'b0;
    core_dec_start = 1'b0;
    core_seed_enc  = '0;
    core_seed_dec  = '0;
    core_p_in      = '0;
    core_c_in      = '0;
    if (drive_core) begin
      if (op_q) begin
        core_dec_start = 1'b1;
        core_seed_dec  = seed_q;
        core_c_in      = data_q;
      end else begin
        core_enc_start = 1'b1;
        core_seed_enc  = seed_q;
        core_p_in      = data_q;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      ptr     <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      first_q <= (state == S_LOAD);
      if (accept) ptr <= ~grant;
    end
  end

  // NOTE: payload registers carry no reset; every output they feed is gated
  // by the state, which is reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      op_q   <= bus.req_op[grant];
      src_q  <= grant;
      data_q <= grant ? bus.req_data1 : bus.req_data0;
      seed_q <= grant ? bus.req_seed1 : bus.req_seed0;
    end
    if (done_ok)       result_q <= op_q ? core_p_out : core_c_out;
    else if (wdog_hit) result_q <= '0;
  end

endmodule

// File: tb/tb_rc5_job_scheduler.sv
// Directed bench for rc5_job_scheduler with a table-driven stand-in for the RC5 core.
module tb_rc5_job_scheduler;
  localparam int W   = 16;
  localparam int LAT = 3;

  logic         clock = 1'b0;
  logic         reset;
  logic         busy, core_run, core_enc_start, core_dec_start;
  logic [7:0]   core_seed_enc, core_seed_dec;
  logic [W-1:0] core_p_in, core_c_in, core_c_out, core_p_out;
  logic         core_enc_done, core_dec_done;
  logic         hold_done;
  int           enc_cnt, dec_cnt;
  int           n_pass = 0;
  int           n_total = 0;

  always #5 clock = ~clock;

  rc5_job_scheduler_if #(.W(W)) bus ();

  rc5_job_scheduler #(.W(W), .R(3), .TO_CYC(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .busy           (busy),
    .core_run       (core_run),
    .core_enc_start (core_enc_start),
    .core_dec_start (core_dec_start),
    .core_seed_enc  (core_seed_enc),
    .core_seed_dec  (core_seed_dec),
    .core_p_in      (core_p_in),
    .core_c_in      (core_c_in),
    .core_c_out     (core_c_out),
    .core_p_out     (core_p_out),
    .core_enc_done  (core_enc_done),
    .core_dec_done  (core_dec_done)
  );

  function automatic logic [15:0] enc_f(input logic [15:0] p);
    case (p)
      16'h1000: return 16'h5460;
      16'hFFFF: return 16'hA788;
      16'h0000: return 16'hAD6D;
      default:  return 16'hDEAD;
    endcase
  endfunction

  function automatic logic [15:0] dec_f(input logic [15:0] c);
    case (c)
      16'h5460: return 16'h1000;
      16'hA788: return 16'hFFFF;
      16'hAD6D: return 16'h0000;
      default:  return 16'hBEEF;
    endcase
  endfunction

  // Core stand-in: done is a level that survives core_run low and clears in the first run cycle.
  always @(posedge clock) begin
    if (reset) begin
      enc_cnt <= 0; dec_cnt <= 0;
      core_enc_done <= 1'b0; core_dec_done <= 1'b0;
      core_c_out <= '0; core_p_out <= '0;
    end else if (!core_run) begin
      enc_cnt <= 0; dec_cnt <= 0;
    end else begin
      if (core_enc_start) begin
        enc_cnt <= enc_cnt + 1;
        if (enc_cnt == 0) core_enc_done <= 1'b0;
        else if (enc_cnt == LAT && !hold_done) begin
          core_enc_done <= 1'b1;
          core_c_out    <= enc_f(core_p_in);
        end
      end
      if (core_dec_start) begin
        dec_cnt <= dec_cnt + 1;
        if (dec_cnt == 0) core_dec_done <= 1'b0;
        else if (dec_cnt == LAT && !hold_done) begin
          core_dec_done <= 1'b1;
          core_p_out    <= dec_f(core_c_in);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (!bus.rsp_valid && cycles < 200) begin
      @(negedge clock);
      cycles++;
    end
    check("rsp_timeout", 32'(cycles < 200), 32'd1);
  endtask

  // Presents a job, checks grant/LOAD/first RUN cycle; returns at first RUN negedge.
  task automatic start_job(input int idx, input logic op, input logic [15:0] data,
                           input logic [1:0] exp_ready, input bit keep);
    bus.req_valid[idx] = 1'b1;
    bus.req_op[idx]    = op;
    if (idx == 0) bus.req_data0 = data;
    else          bus.req_data1 = data;
    #1;
    check("grant", 32'(bus.req_ready), 32'(exp_ready));
    @(posedge clock);
    @(negedge clock);
    if (!keep) bus.req_valid[idx] = 1'b0;
    check("load_ctl", {busy, core_run, core_enc_start, core_dec_start}, {2'b10, ~op, op});
    check("load_data", op ? core_c_in : core_p_in, data);
    check("load_seed", op ? core_seed_dec : core_seed_enc, 32'hFF);
    check("load_other", op ? {core_p_in, core_seed_enc} : {core_c_in, core_seed_dec}, 32'd0);
    @(negedge clock);
    check("run_ctl", {core_run, core_enc_start, core_dec_start}, {1'b1, ~op, op});
  endtask

  task automatic finish_rsp(input logic [15:0] exp_data, input logic exp_src, input logic exp_op);
    int cyc;
    wait_rsp(cyc);
    check("rsp_latency", cyc, LAT + 2);
    check("rsp_data", bus.rsp_data, exp_data);
    check("rsp_tag", {bus.rsp_src, bus.rsp_op, bus.rsp_err}, {exp_src, exp_op, 1'b0});
    check("rsp_no_ready", 32'(bus.req_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    check("rsp_done", {busy, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int  cyc;
    logic seen;
    reset = 1'b1;
    hold_done = 1'b0;
    bus.req_valid = 2'b00; bus.req_op = 2'b00;
    bus.req_data0 = '0; bus.req_data1 = '0;
    bus.req_seed0 = 8'hFF; bus.req_seed1 = 8'hFF;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_ctl", {bus.req_ready, bus.rsp_valid, busy, core_run, core_enc_start,
                        core_dec_start, bus.rsp_src, bus.rsp_op, bus.rsp_err}, 32'd0);
    check("reset_data", {bus.rsp_data, core_p_in}, 32'd0);

    // 1: req0 encrypt, 2: req1 decrypt
    start_job(0, 1'b0, 16'h1000, 2'b01, 1'b0);
    finish_rsp(16'h5460, 1'b0, 1'b0);
    start_job(1, 1'b1, 16'h5460, 2'b10, 1'b0);
    finish_rsp(16'h1000, 1'b1, 1'b1);

    // 3: both valid, pointer back at requester 0
    bus.req_valid[1] = 1'b1; bus.req_op[1] = 1'b1; bus.req_data1 = 16'hAD6D;
    start_job(0, 1'b0, 16'hFFFF, 2'b01, 1'b0);
    finish_rsp(16'hA788, 1'b0, 1'b0);
    start_job(1, 1'b1, 16'hAD6D, 2'b10, 1'b0);
    finish_rsp(16'h0000, 1'b1, 1'b1);

    // Both held valid: grants alternate
    bus.req_valid = 2'b11; bus.req_op = 2'b00;
    bus.req_data0 = 16'h1000; bus.req_data1 = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        start_job(0, 1'b0, 16'h1000, 2'b01, 1'b1);
        finish_rsp(16'h5460, 1'b0, 1'b0);
      end else begin
        start_job(1, 1'b0, 16'hFFFF, 2'b10, 1'b1);
        finish_rsp(16'hA788, 1'b1, 1'b0);
      end
    end
    bus.req_valid = 2'b00;

    // 4: response back-pressure with a pending request
    start_job(0, 1'b0, 16'h1000, 2'b01, 1'b1);
    wait_rsp(cyc);
    for (int i = 0; i < 20; i++) begin
      check("hold", {bus.rsp_valid, busy, bus.req_ready, bus.rsp_data, bus.rsp_src, bus.rsp_op},
            {1'b1, 1'b1, 2'b00, 16'h5460, 1'b0, 1'b0});
      @(negedge clock);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("no_same_cycle", 32'(bus.req_ready), 32'd0);
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    check("idle_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 2'b00;
    #1;
    check("drop_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clock);
    check("drop_idle", {busy, core_run, core_enc_start}, 32'd0);

    // 5: reset mid RUN discards the job
    start_job(1, 1'b0, 16'h0000, 2'b10, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_ctl", {bus.req_ready, bus.rsp_valid, busy, core_run, core_enc_start,
                         core_dec_start, bus.rsp_src, bus.rsp_op, bus.rsp_err}, 32'd0);
    check("midrst_data", {bus.rsp_data, core_p_in}, 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      seen = seen | bus.rsp_valid | busy;
    end
    check("midrst_quiet", 32'(seen), 32'd0);
    start_job(0, 1'b0, 16'h0000, 2'b01, 1'b0);
    finish_rsp(16'hAD6D, 1'b0, 1'b0);

`ifdef RC5_SCHED_WDOG_EN
    // 6: watchdog abort after TO_CYC=8 RUN clocks
    hold_done = 1'b1;
    start_job(0, 1'b0, 16'h1000, 2'b01, 1'b0);
    wait_rsp(cyc);
    check("wdog_latency", cyc, 8);
    check("wdog_rsp", {bus.rsp_data, bus.rsp_src, bus.rsp_err}, {16'h0000, 1'b0, 1'b1});
    hold_done = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    check("wdog_idle", {busy, bus.rsp_valid}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
